// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// Sequential word fetcher feeding a byte-addressed memory; presents words downstream
// through a valid/ready output register, with a skid entry for the registered read path.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          RD_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  output logic        mem_wr_en,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  logic [31:0] fetch_pc;
  logic [31:0] target_pc;
  logic        consume;

  assign mem_addr    = fetch_pc;
  assign mem_wr_en   = 1'b0;
  assign mem_data_in = 32'h0000_0000;
  assign target_pc   = redirect_pc & 32'hFFFF_FFFC;
  assign consume     = instr_valid && instr_ready;

  if (RD_LAT == 0) begin : g_comb_read
    logic issue;
    assign issue = !stall && !redirect && (!instr_valid || instr_ready);

    // address stage and capture stage collapse into one edge
    always_ff @(posedge clk) begin
      if (rst) begin
        fetch_pc    <= RESET_PC;
        instr       <= 32'h0;
        instr_pc    <= 32'h0;
        instr_valid <= 1'b0;
      end else if (redirect) begin
        fetch_pc    <= target_pc;
        instr_valid <= 1'b0;
      end else if (issue) begin
        fetch_pc    <= fetch_pc + 32'd4;
        instr       <= mem_rdata;
        instr_pc    <= fetch_pc;
        instr_valid <= 1'b1;
      end else if (consume) begin
        instr_valid <= 1'b0;
      end
    end
  end else begin : g_reg_read
    logic        inflight;
    logic [31:0] req_pc;
    logic [31:0] skid_word;
    logic [31:0] skid_pc;
    logic        skid_valid;
    logic [1:0]  occ;
    logic [1:0]  occ_after;
    logic        issue;

    // every issued word must have a slot reserved in output reg or skid
    assign occ       = 2'(instr_valid) + 2'(skid_valid) + 2'(inflight);
    assign occ_after = occ - 2'(consume);
    assign issue     = !stall && !redirect && (occ_after < 2'd2);

    // request stage: issue address; response stage: land word in output or skid
    always_ff @(posedge clk) begin
      if (rst) begin
        fetch_pc    <= RESET_PC;
        instr       <= 32'h0;
        instr_pc    <= 32'h0;
        instr_valid <= 1'b0;
        inflight    <= 1'b0;
        skid_valid  <= 1'b0;
      end else if (redirect) begin
        fetch_pc    <= target_pc;
        instr_valid <= 1'b0;
        skid_valid  <= 1'b0;
        inflight    <= 1'b0;
      end else begin
        inflight <= issue;
        if (issue) begin
          fetch_pc <= fetch_pc + 32'd4;
          req_pc   <= fetch_pc;
        end
        if (consume) begin
          if (skid_valid) begin
            instr    <= skid_word;
            instr_pc <= skid_pc;
            if (inflight) begin
              skid_word <= mem_rdata;
              skid_pc   <= req_pc;
            end else begin
              skid_valid <= 1'b0;
            end
          end else if (inflight) begin
            instr    <= mem_rdata;
            instr_pc <= req_pc;
          end else begin
            instr_valid <= 1'b0;
          end
        end else if (inflight) begin
          if (!instr_valid) begin
            instr       <= mem_rdata;
            instr_pc    <= req_pc;
            instr_valid <= 1'b1;
          end else begin
            skid_word  <= mem_rdata;
            skid_pc    <= req_pc;
            skid_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// Drives a combinational-read and a registered-read fetch_unit with shared stimulus and
// checks both against a queue-level model of the fetch stream every cycle.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, instr_ready;
  logic [31:0] redirect_pc;

  logic [31:0] addr0, rdata0, instr0, ipc0, din0;
  logic        ivld0, wr0;
  logic [31:0] addr1, rdata1, instr1, ipc1, din1;
  logic        ivld1, wr1;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h0011_2233;
      32'd4:   return 32'h4455_6677;
      32'd8:   return 32'h8899_AABB;
      32'd12:  return 32'hCCDD_EEFF;
      default: return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  assign rdata0 = memword(addr0);
  always @(posedge clk) rdata1 <= memword(addr1);

  fetch_unit #(.RESET_PC(RESET_PC), .RD_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_addr(addr0), .mem_wr_en(wr0), .mem_data_in(din0), .mem_rdata(rdata0),
    .instr(instr0), .instr_pc(ipc0), .instr_valid(ivld0), .instr_ready(instr_ready));

  fetch_unit #(.RESET_PC(RESET_PC), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_addr(addr1), .mem_wr_en(wr1), .mem_data_in(din1), .mem_rdata(rdata1),
    .instr(instr1), .instr_pc(ipc1), .instr_valid(ivld1), .instr_ready(instr_ready));

  // Model: per latency, next fetch address, an ordered queue of deliverable words
  // (front = what the output shows) and at most one outstanding registered read.
  typedef struct packed { logic [31:0] word; logic [31:0] pc; } ent_t;
  ent_t        m_q  [2][2];
  int          m_n  [2];
  logic [31:0] m_pc [2];
  bit          m_infl [2];
  logic [31:0] m_req [2];
  bit          cons, iss;

  initial begin
    for (int l = 0; l < 2; l++) begin
      m_n[l] = 0; m_pc[l] = RESET_PC; m_infl[l] = 1'b0; m_req[l] = 32'h0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int l, input logic [31:0] w, input logic [31:0] p);
    if (m_n[l] < 2) begin
      m_q[l][m_n[l]].word = w;
      m_q[l][m_n[l]].pc   = p;
      m_n[l]++;
    end else begin
      tests++; fails++;
      $display("FAIL model_depth lat%0d: got %0d entries expected at most 2", l, m_n[l] + 1);
    end
  endtask

  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (rst) begin
        m_pc[l] = RESET_PC; m_n[l] = 0; m_infl[l] = 1'b0;
      end else if (redirect) begin
        m_pc[l] = redirect_pc & 32'hFFFF_FFFC; m_n[l] = 0; m_infl[l] = 1'b0;
      end else begin
        cons = (m_n[l] > 0) && instr_ready;
        if (l == 0) iss = !stall && (m_n[l] == 0 || instr_ready);
        else        iss = !stall && (m_n[l] + int'(m_infl[l]) - int'(cons) < 2);
        if (cons) begin
          m_q[l][0] = m_q[l][1];
          m_n[l]--;
        end
        if (l == 1 && m_infl[l]) push(l, memword(m_req[l]), m_req[l]);
        if (iss && l == 0) push(l, memword(m_pc[l]), m_pc[l]);
        m_infl[l] = iss && (l == 1);
        if (iss) begin
          m_req[l] = m_pc[l];
          m_pc[l]  = m_pc[l] + 32'd4;
        end
      end
    end
  end

  task automatic cmp(input string tag, input int l, input logic [31:0] a, input logic v,
                     input logic [31:0] i, input logic [31:0] ip, input logic we,
                     input logic [31:0] di);
    check({tag, "_mem_addr"}, a, m_pc[l]);
    check({tag, "_instr_valid"}, {31'b0, v}, {31'b0, (m_n[l] > 0)});
    if (m_n[l] > 0) begin
      check({tag, "_instr"}, i, m_q[l][0].word);
      check({tag, "_instr_pc"}, ip, m_q[l][0].pc);
    end
    check({tag, "_mem_wr_en"}, {31'b0, we}, 32'h0);
    check({tag, "_mem_data_in"}, di, 32'h0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("lat0", 0, addr0, ivld0, instr0, ipc0, wr0, din0);
      cmp("lat1", 1, addr1, ivld1, instr1, ipc1, wr1, din1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b1;
    cyc(2);
    chk_en = 1'b1;
    check("reset_addr1", addr1, 32'h0);
    check("reset_valid1", {31'b0, ivld1}, 32'h0);
    check("reset_instr1", instr1, 32'h0);

    // free run from reset
    rst = 1'b0;
    cyc(1);
    check("run_first_valid1", {31'b0, ivld1}, 32'h0);
    check("run_addr1_e1", addr1, 32'h4);
    check("run_instr0_e1", instr0, 32'h0011_2233);
    cyc(1);
    check("run_valid1_e2", {31'b0, ivld1}, 32'h1);
    check("run_instr1_e2", instr1, 32'h0011_2233);
    check("run_ipc1_e2", ipc1, 32'h0);
    cyc(3);
    check("run_instr1_e5", instr1, 32'hCCDD_EEFF);

    // backpressure fills output reg and skid, then drains in order
    rst = 1'b1; instr_ready = 1'b0;
    cyc(1);
    rst = 1'b0;
    cyc(6);
    check("bp_instr1_held", instr1, 32'h0011_2233);
    check("bp_addr1_frozen", addr1, 32'h8);
    instr_ready = 1'b1;
    cyc(1);
    check("bp_drain_instr1_a", instr1, 32'h4455_6677);
    check("bp_drain_ipc1_a", ipc1, 32'h4);
    cyc(1);
    check("bp_drain_instr1_b", instr1, 32'h8899_AABB);

    // reset while skid holds a word
    instr_ready = 1'b0;
    cyc(3);
    check("skid_addr1", addr1, 32'h10);
    check("skid_ipc1", ipc1, 32'h8);
    rst = 1'b1;
    cyc(1);
    check("midrst_valid1", {31'b0, ivld1}, 32'h0);
    check("midrst_addr1", addr1, RESET_PC);
    check("midrst_valid0", {31'b0, ivld0}, 32'h0);
    rst = 1'b0; instr_ready = 1'b1;
    cyc(4);

    // redirect with a word in flight
    redirect = 1'b1; redirect_pc = 32'h0000_000B;
    cyc(1);
    check("redir_addr1", addr1, 32'h8);
    check("redir_valid1", {31'b0, ivld1}, 32'h0);
    redirect = 1'b0;
    cyc(1);
    check("redir_valid1_r1", {31'b0, ivld1}, 32'h0);
    cyc(1);
    check("redir_instr1_r2", instr1, 32'h8899_AABB);
    check("redir_ipc1_r2", ipc1, 32'h8);

    // address wrap
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc(1);
    check("wrap_addr1_a", addr1, 32'hFFFF_FFFC);
    redirect = 1'b0;
    cyc(1);
    check("wrap_addr1_b", addr1, 32'h0);
    cyc(1);
    check("wrap_addr1_c", addr1, 32'h4);
    cyc(2);

    // redirect together with stall, stall held afterwards
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0004;
    cyc(1);
    redirect = 1'b0;
    cyc(2);
    check("stredir_addr1", addr1, 32'h4);
    check("stredir_valid1", {31'b0, ivld1}, 32'h0);
    stall = 1'b0;
    cyc(3);

    // stall mid-stream on the combinational path
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(3);
    check("stall_pre_addr0", addr0, 32'hC);
    check("stall_pre_instr0", instr0, 32'h8899_AABB);
    stall = 1'b1;
    cyc(3);
    check("stall_addr0", addr0, 32'hC);
    check("stall_valid0", {31'b0, ivld0}, 32'h0);
    stall = 1'b0;
    cyc(1);
    check("stall_resume_instr0", instr0, 32'hCCDD_EEFF);
    check("stall_resume_ipc0", ipc0, 32'hC);
    check("stall_resume_addr0", addr0, 32'h10);
    cyc(3);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
